// File: rtl/find_extreme_stream.sv
// Streaming max/min search over LANES elements per beat. It reports the value, position and unmasked count for each frame.
// m_valid rises on the second enabled rising edge counting the edge that takes s_last. A stalled result stalls the whole pipe and s_ready.
module find_extreme_stream #(
  parameter int BWID   = 16,
  parameter int LANES  = 4,
  parameter int IWID   = 16,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mode,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [BWID*LANES-1:0] s_data,
  input  logic [LANES-1:0]      s_mask,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [BWID-1:0]       m_data,
  output logic [IWID-1:0]       m_index,
  output logic [IWID-1:0]       m_count,
  output logic                  m_empty
);

  localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW  = $clog2(LANES + 1);
  localparam int IW1 = IWID + 1;

  // Strict comparison: a candidate only displaces the incumbent if it is better.
  // Equal values therefore resolve to the lower position.
  function automatic logic better(input logic [BWID-1:0] a, input logic [BWID-1:0] b,
                                  input logic mn);
    logic gt, lt;
    if (SIGNED != 0) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return mn ? lt : gt;
  endfunction

  logic            en;
  logic            accept;
  logic            mode_use;

  logic [IWID-1:0] pos_q;
  logic            first_q;
  logic            mode_q;

  logic            s1_vld_q, s1_last_q, s1_any_q, s1_mode_q;
  logic [BWID-1:0] s1_val_q;
  logic [IWID-1:0] s1_idx_q;
  logic [CW-1:0]   s1_cnt_q;

  logic            acc_any_q;
  logic [BWID-1:0] acc_val_q;
  logic [IWID-1:0] acc_idx_q;
  logic [IWID-1:0] acc_cnt_q;

  logic            m_valid_q, m_empty_q;
  logic [BWID-1:0] m_data_q;
  logic [IWID-1:0] m_index_q, m_count_q;

  logic            lw_any;
  logic [BWID-1:0] lw_val;
  logic [LW-1:0]   lw_lane;
  logic [CW-1:0]   lw_cnt;

  logic            take;
  logic            acc_any_d;
  logic [BWID-1:0] acc_val_d;
  logic [IWID-1:0] acc_idx_d;
  logic [IWID-1:0] acc_cnt_d;
  logic [IW1-1:0]  cnt_sum;

  assign en       = !m_valid_q || m_ready;
  assign s_ready  = en;
  assign accept   = s_valid && en;
  assign mode_use = first_q ? i_mode : mode_q;

  // Beat-local winner, scanned from lane 0 upward.
  always_comb begin
    lw_any  = 1'b0;
    lw_val  = '0;
    lw_lane = '0;
    lw_cnt  = '0;
    for (int k = 0; k < LANES; k++) begin
      if (s_mask[k]) begin
        lw_cnt = lw_cnt + CW'(1);
        if (!lw_any || better(s_data[k*BWID +: BWID], lw_val, mode_use)) begin
          lw_any  = 1'b1;
          lw_val  = s_data[k*BWID +: BWID];
          lw_lane = LW'(k);
        end
      end
    end
  end

  // The accumulator holds earlier positions, so it keeps ties.
  always_comb begin
    take      = s1_any_q && (!acc_any_q || better(s1_val_q, acc_val_q, s1_mode_q));
    acc_any_d = acc_any_q || s1_any_q;
    acc_val_d = take ? s1_val_q : acc_val_q;
    acc_idx_d = take ? s1_idx_q : acc_idx_q;
    cnt_sum   = {1'b0, acc_cnt_q} + IW1'(s1_cnt_q);
    acc_cnt_d = cnt_sum[IWID] ? {IWID{1'b1}} : cnt_sum[IWID-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q     <= '0;
      first_q   <= 1'b1;
      mode_q    <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_any_q  <= 1'b0;
      s1_mode_q <= 1'b0;
      s1_val_q  <= '0;
      s1_idx_q  <= '0;
      s1_cnt_q  <= '0;
      acc_any_q <= 1'b0;
      acc_val_q <= '0;
      acc_idx_q <= '0;
      acc_cnt_q <= '0;
      m_valid_q <= 1'b0;
      m_empty_q <= 1'b0;
      m_data_q  <= '0;
      m_index_q <= '0;
      m_count_q <= '0;
    end else if (en) begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_last_q <= s_last;
        s1_any_q  <= lw_any;
        s1_mode_q <= mode_use;
        s1_val_q  <= lw_val;
        s1_idx_q  <= pos_q + IWID'(lw_lane);
        s1_cnt_q  <= lw_cnt;
        pos_q     <= s_last ? '0 : pos_q + IWID'(LANES);
        first_q   <= s_last;
        mode_q    <= mode_use;
      end

      m_valid_q <= s1_vld_q && s1_last_q;
      if (s1_vld_q) begin
        if (s1_last_q) begin
          m_empty_q <= !acc_any_d;
          m_data_q  <= acc_any_d ? acc_val_d : '0;
          m_index_q <= acc_any_d ? acc_idx_d : '0;
          m_count_q <= acc_cnt_d;
          acc_any_q <= 1'b0;
          acc_val_q <= '0;
          acc_idx_q <= '0;
          acc_cnt_q <= '0;
        end else begin
          acc_any_q <= acc_any_d;
          acc_val_q <= acc_val_d;
          acc_idx_q <= acc_idx_d;
          acc_cnt_q <= acc_cnt_d;
        end
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_index = m_index_q;
  assign m_count = m_count_q;
  assign m_empty = m_empty_q;

endmodule

// File: tb/tb_find_extreme_stream.sv
// Directed bench for find_extreme_stream: unsigned and signed instances share one stimulus stream.
module tb_find_extreme_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_mode;
  logic        s_valid;
  logic [63:0] s_data;
  logic [3:0]  s_mask;
  logic        s_last;
  logic        m_ready;

  logic        s_ready_u, m_valid_u, m_empty_u;
  logic [15:0] m_data_u, m_index_u, m_count_u;
  logic        s_ready_s, m_valid_s, m_empty_s;
  logic [15:0] m_data_s, m_index_s, m_count_s;

  int n_err = 0;
  int n_chk = 0;

  logic        mon_en = 1'b0;
  logic [15:0] qd[$];
  logic [15:0] qi[$];
  logic [15:0] qc[$];

  always #5 clk = ~clk;

  find_extreme_stream #(.BWID(16), .LANES(4), .IWID(16), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .i_mode(i_mode), .s_valid(s_valid), .s_ready(s_ready_u),
    .s_data(s_data), .s_mask(s_mask), .s_last(s_last), .m_valid(m_valid_u),
    .m_ready(m_ready), .m_data(m_data_u), .m_index(m_index_u), .m_count(m_count_u),
    .m_empty(m_empty_u));

  find_extreme_stream #(.BWID(16), .LANES(4), .IWID(16), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .i_mode(i_mode), .s_valid(s_valid), .s_ready(s_ready_s),
    .s_data(s_data), .s_mask(s_mask), .s_last(s_last), .m_valid(m_valid_s),
    .m_ready(m_ready), .m_data(m_data_s), .m_index(m_index_s), .m_count(m_count_s),
    .m_empty(m_empty_s));

  always @(negedge clk) begin
    if (mon_en && m_valid_u && m_ready) begin
      qd.push_back(m_data_u);
      qi.push_back(m_index_u);
      qc.push_back(m_count_u);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  task automatic send(input logic [63:0] d, input logic [3:0] mk, input logic lst,
                      input logic md);
    bit taken;
    int budget;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_mask  = mk;
    s_last  = lst;
    i_mode  = md;
    taken   = 1'b0;
    budget  = 0;
    while (!taken && budget < 50) begin
      taken = s_ready_u;
      @(posedge clk);
      budget++;
      if (!taken) @(negedge clk);
    end
    if (!taken) chk("send_accept", {63'd0, s_ready_u}, 64'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    idle();
    for (int i = 0; i < 20; i++) begin
      if (m_valid_u) break;
      @(negedge clk);
    end
    chk({tag, "_valid"}, m_valid_u, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_mode = 1'b0; s_valid = 1'b0; s_data = '0;
    s_mask = '0; s_last = 1'b0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_m_valid", m_valid_u, 0);
    chk("rst_s_ready", s_ready_u, 1);
    chk("rst_m_count", m_count_u, 0);
    chk("rst_m_empty", m_empty_u, 0);
    rst = 1'b0;

    // Max, tie on 9 across beats resolves to the earlier position
    send(pk(3, 9, 1, 2), 4'hF, 1'b0, 1'b0);
    send(pk(9, 4, 0, 7), 4'hF, 1'b1, 1'b0);
    idle();
    chk("t1_lat_early", m_valid_u, 0);
    @(negedge clk);
    chk("t1_valid", m_valid_u, 1);
    chk("t1_data", m_data_u, 9);
    chk("t1_index", m_index_u, 1);
    chk("t1_count", m_count_u, 8);
    chk("t1_empty", m_empty_u, 0);

    // Min, signed versus unsigned interpretation of the same beat
    send(pk(16'h0005, 16'hFFFE, 16'h8000, 16'h7FFF), 4'hF, 1'b1, 1'b1);
    wait_res("t2");
    chk("t2s_data", m_data_s, 16'h8000);
    chk("t2s_index", m_index_s, 2);
    chk("t2s_count", m_count_s, 4);
    chk("t2u_data", m_data_u, 16'h0005);
    chk("t2u_index", m_index_u, 0);

    // Masked lanes consume positions but never compete
    send(pk(9, 9, 9, 9), 4'b0000, 1'b0, 1'b0);
    send(pk(1, 1, 1, 1), 4'b0011, 1'b1, 1'b0);
    wait_res("t3");
    chk("t3_data", m_data_u, 1);
    chk("t3_index", m_index_u, 4);
    chk("t3_count", m_count_u, 2);
    chk("t3_empty", m_empty_u, 0);
    send(pk(7, 7, 7, 7), 4'b0000, 1'b1, 1'b0);
    wait_res("t3e");
    chk("t3e_empty", m_empty_u, 1);
    chk("t3e_count", m_count_u, 0);
    chk("t3e_data", m_data_u, 0);
    chk("t3e_index", m_index_u, 0);

    // Downstream stall: result held, input blocked, pending beat kept
    idle();
    m_ready = 1'b0;
    send(pk(4, 3, 2, 1), 4'hF, 1'b1, 1'b0);
    wait_res("t4a");
    chk("t4a_data", m_data_u, 4);
    chk("t4a_index", m_index_u, 0);
    s_valid = 1'b1; s_data = pk(1, 2, 3, 5); s_mask = 4'hF; s_last = 1'b1; i_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_s_ready", s_ready_u, 0);
      chk("t4_hold_valid", m_valid_u, 1);
      chk("t4_hold_data", m_data_u, 4);
      chk("t4_hold_count", m_count_u, 4);
    end
    m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    chk("t4_drain", m_valid_u, 0);
    @(negedge clk);
    chk("t4b_valid", m_valid_u, 1);
    chk("t4b_data", m_data_u, 5);
    chk("t4b_index", m_index_u, 3);
    chk("t4b_count", m_count_u, 4);

    // Reset mid-frame discards the partial frame
    send(pk(100, 200, 300, 400), 4'hF, 1'b0, 1'b0);
    send(pk(100, 200, 300, 400), 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", m_valid_u, 0);
    chk("t5_rst_ready", s_ready_u, 1);
    @(negedge clk);
    rst = 1'b0;
    send(pk(5, 6, 7, 8), 4'hF, 1'b1, 1'b0);
    wait_res("t5");
    chk("t5_data", m_data_u, 8);
    chk("t5_index", m_index_u, 3);
    chk("t5_count", m_count_u, 4);

    // Back-to-back frames, i_mode flipped on the second beat of each
    idle();
    qd.delete(); qi.delete(); qc.delete();
    mon_en = 1'b1;
    send(pk(1, 7, 3, 2), 4'hF, 1'b0, 1'b0);
    send(pk(0, 8, 0, 0), 4'hF, 1'b1, 1'b1);
    send(pk(6, 4, 9, 5), 4'hF, 1'b0, 1'b1);
    send(pk(3, 5, 2, 7), 4'hF, 1'b1, 1'b0);
    idle();
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    chk("t6_nres", qd.size(), 2);
    if (qd.size() == 2) begin
      chk("t6a_data", qd[0], 8);
      chk("t6a_index", qi[0], 5);
      chk("t6a_count", qc[0], 8);
      chk("t6b_data", qd[1], 2);
      chk("t6b_index", qi[1], 6);
      chk("t6b_count", qc[1], 8);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
